if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and drives a multi-cycle instruction-memory request/ready handshake.
- Applies the decoder's PCSrc redirects (jr, j/jal, taken beq) and the stall and flush requests.
- Presents the decoded-stage instruction, its opc/func fields and PC+4 to the ID-stage controller and datapath.

---
 rtl/if_id_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Owns the PC, runs the imem request/ready handshake, applies PCSrc redirects, stall and flush.
module if_id_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jr_addr,
  input  logic [31:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [5:0]  opc,
  output logic [5:0]  func
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] PCSRC_JR  = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_SEQ = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   req_addr, req_addr_d;
  logic [XLEN-1:0]   pend, pend_d;
  logic [XLEN-1:0]   hold_buf, hold_buf_d;
  logic [XLEN-1:0]   id_instr_d, id_pc_plus4_d;
  logic              id_valid_d, imem_req_d;
  logic              redirect, deliver;
  logic [XLEN-1:0]   target, seq_addr, deliver_instr;

  assign redirect  = id_valid & ~stall & (pc_src != PCSRC_SEQ);
  assign seq_addr  = req_addr + XLEN'(4);
  assign imem_addr = req_addr;
  assign opc       = id_instr[31:26];
  assign func      = id_instr[5:0];

  // Redirect target for the instruction currently in IF/ID
  always_comb begin
    target = jr_addr;
    case (pc_src)
      PCSRC_JR: target = jr_addr;
      PCSRC_J:  target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
      PCSRC_BR: target = id_pc_plus4 + (branch_offset << 2);
      default:  target = jr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state, fetch-side registers and IF/ID update
  always_comb begin
    state_d       = state;
    req_addr_d    = req_addr;
    pend_d        = pend;
    hold_buf_d    = hold_buf;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    id_instr_d    = id_instr;
    id_pc_plus4_d = id_pc_plus4;
    id_valid_d    = id_valid;

    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect) begin
          if (imem_ready) begin
            req_addr_d = target;
          end else begin
            pend_d  = target;
            state_d = DROP;
          end
        end else if (imem_ready) begin
          if (stall) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            deliver    = 1'b1;
            req_addr_d = seq_addr;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          req_addr_d = target;
          state_d    = REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_buf;
          req_addr_d    = seq_addr;
          state_d       = REQ;
        end
      end
      DROP: begin
        // The wrong-path word still has to retire before the pending target goes out
        if (imem_ready) begin
          req_addr_d = pend;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    imem_req_d = (state_d == REQ) || (state_d == DROP);

    if (flush || redirect) begin
      id_instr_d = '0;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        id_instr_d    = deliver_instr;
        id_pc_plus4_d = seq_addr;
        id_valid_d    = 1'b1;
      end else begin
        id_instr_d = '0;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr    <= PC_RESET;
      pend        <= PC_RESET;
      hold_buf    <= '0;
      imem_req    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else begin
      req_addr    <= req_addr_d;
      pend        <= pend_d;
      hold_buf    <= hold_buf_d;
      imem_req    <= imem_req_d;
      id_instr    <= id_instr_d;
      id_pc_plus4 <= id_pc_plus4_d;
      id_valid    <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed redirect/stall/flush/reset scenarios
// against a variable-latency instruction memory.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] jr_addr, branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] id_instr, id_pc_plus4;
  logic        id_valid;
  logic [5:0]  opc, func;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int mcnt = 0;
  logic stall_q = 1'b0;
  logic [31:0] exp_fetch[$];
  logic [63:0] exp_id[$];

  if_id_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
    .jr_addr(jr_addr), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .opc(opc), .func(func)
  );

  always #5 clk = ~clk;

  // Address-tagged memory contents; 0x8000_000C holds "j 0x40"
  function automatic logic [31:0] tag(input logic [31:0] a);
    if (a == 32'h8000_000C) return 32'h0800_0040;
    return a ^ 32'hC000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [31:0] a);
    exp_fetch.push_back(a);
  endtask

  task automatic push_i(input logic [31:0] instr, input logic [31:0] pc4);
    exp_id.push_back({instr, pc4});
  endtask

  task automatic wait_id(input logic [31:0] pc4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (id_valid && id_pc_plus4 == pc4) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_id timeout actual=%h required=%h", id_pc_plus4, pc4);
  endtask

  task automatic wait_fetch(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_addr == a) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_fetch timeout actual=%h required=%h", imem_addr, a);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h0);
  endtask

  // Memory: ready after lat cycles of an outstanding request, tolerates req dropping
  always @(negedge clk) begin
    if (!imem_req) begin
      mcnt = 0;
      imem_ready = 1'b0;
    end else begin
      if (imem_ready) mcnt = 0;
      mcnt++;
      imem_ready = (mcnt >= lat);
    end
    imem_rdata = tag(imem_addr);
  end

  always @(posedge clk) stall_q <= stall;

  // Monitor: completed fetches and newly loaded IF/ID slots against the scoreboard
  always begin
    logic [31:0] ef;
    logic [63:0] ei;
    @(negedge clk); #2;
    if (imem_req && imem_ready) begin
      if (exp_fetch.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fetch_unexpected actual=%h required=none", imem_addr);
      end else begin
        ef = exp_fetch.pop_front();
        check("fetch_addr", imem_addr, ef);
      end
    end
    if (id_valid && !stall_q) begin
      if (exp_id.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL id_unexpected actual=%h required=none", id_instr);
      end else begin
        ei = exp_id.pop_front();
        check("id_instr", id_instr, ei[63:32]);
        check("id_pc_plus4", id_pc_plus4, ei[31:0]);
        check("opc", 32'(opc), 32'(ei[63:58]));
        check("func", 32'(func), 32'(ei[37:32]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b11;
    jr_addr = 32'h0; branch_offset = 32'h0;
    repeat (2) @(negedge clk); #1;
    check_reset_outputs();

    // Sequential fetch, then a 3-cycle stall on the word at 0x10
    for (int a = 0; a <= 'h14; a += 4) begin
      push_f(32'(a));
      push_i(tag(32'(a)), 32'(a + 4));
    end
    rst = 1'b1;
    wait_fetch(32'h10);
    stall = 1'b1;
    @(negedge clk); #1;
    check("hold_req", 32'(imem_req), 32'h0);
    check("hold_freeze", id_instr, tag(32'hC));
    @(negedge clk); #1;
    check("hold_req2", 32'(imem_req), 32'h0);
    @(negedge clk); #1;
    stall = 1'b0;
    @(negedge clk); #1;
    check("resume_addr", imem_addr, 32'h14);
    check("resume_instr", id_instr, tag(32'h10));
    check("resume_pc4", id_pc_plus4, 32'h14);

    // beq, jr, j, jr, then flush+stall
    push_f(32'h18); push_f(32'h1C); push_f(32'h20); push_f(32'h18); push_f(32'h1C);
    push_f(32'h8000_000C); push_f(32'h8000_0010); push_f(32'h8000_0100);
    push_f(32'h8000_0104); push_f(32'h44); push_f(32'h48); push_f(32'h4C);
    push_i(tag(32'h18), 32'h1C); push_i(tag(32'h1C), 32'h20); push_i(tag(32'h18), 32'h1C);
    push_i(32'h0800_0040, 32'h8000_0010); push_i(tag(32'h8000_0100), 32'h8000_0104);
    push_i(tag(32'h44), 32'h48); push_i(tag(32'h48), 32'h4C);

    wait_id(32'h20);
    pc_src = 2'b10; branch_offset = 32'hFFFF_FFFE;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("br_addr", imem_addr, 32'h18);
    check("br_bubble_valid", 32'(id_valid), 32'h0);
    check("br_bubble_instr", id_instr, 32'h0);
    check("br_bubble_pc4", id_pc_plus4, 32'h20);

    wait_id(32'h1C);
    pc_src = 2'b00; jr_addr = 32'h8000_000C;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("jr_addr_hi", imem_addr, 32'h8000_000C);

    wait_id(32'h8000_0010);
    pc_src = 2'b01;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("j_addr", imem_addr, 32'h8000_0100);

    wait_id(32'h8000_0104);
    pc_src = 2'b00; jr_addr = 32'h44;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("jr_addr", imem_addr, 32'h44);

    wait_id(32'h48);
    flush = 1'b1; stall = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0; stall = 1'b0;
    check("flush_valid", 32'(id_valid), 32'h0);
    check("flush_req", 32'(imem_req), 32'h0);
    check("flush_pc4", id_pc_plus4, 32'h48);

    // 3-cycle memory: redirect during the first wait cycle of 0x30
    wait_id(32'h4C);
    lat = 3;
    pc_src = 2'b00; jr_addr = 32'h2C;
    push_f(32'h2C); push_f(32'h30); push_f(32'h200);
    push_i(tag(32'h2C), 32'h30); push_i(tag(32'h200), 32'h204);
    @(negedge clk); #1;
    pc_src = 2'b11;

    wait_id(32'h30);
    check("wait1_ready", 32'(imem_ready), 32'h0);
    check("wait1_addr", imem_addr, 32'h30);
    pc_src = 2'b00; jr_addr = 32'h200;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("drop_req", 32'(imem_req), 32'h1);
    check("drop_addr", imem_addr, 32'h30);
    check("drop_bubble", 32'(id_valid), 32'h0);
    @(negedge clk); #1;
    check("drop_addr2", imem_addr, 32'h30);
    @(negedge clk); #1;
    check("pend_addr", imem_addr, 32'h200);

    // Reset while in DROP
    wait_id(32'h204);
    pc_src = 2'b00; jr_addr = 32'h300;
    @(negedge clk); #1;
    pc_src = 2'b11;
    check("drop2_addr", imem_addr, 32'h204);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    lat = 1;
    push_f(32'h0); push_f(32'h4); push_f(32'h8);
    push_i(tag(32'h0), 32'h4); push_i(tag(32'h4), 32'h8);
    @(negedge clk); #1;
    check("rst_hold_req", 32'(imem_req), 32'h0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("restart_req", 32'(imem_req), 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    wait_id(32'h8);
    stall = 1'b1;
    repeat (3) @(negedge clk); #3;
    check("end_req", 32'(imem_req), 32'h0);
    check("fetch_q_empty", 32'(exp_fetch.size()), 32'h0);
    check("id_q_empty", 32'(exp_id.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
